// File: rtl/toeplitz_row_gen_pkg.sv
// Shared constants, counter widths and state encoding for the Toeplitz row generator.
package toeplitz_row_gen_pkg;

  localparam int unsigned ROW_W      = 3072;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned FILL_WORDS = ROW_W / WORD_W;
  localparam int unsigned STEPS      = 4096;

  localparam int unsigned STEP_CNT_W = 13;
  localparam int unsigned WORD_CNT_W = 7;
  localparam int unsigned BIT_CNT_W  = 6;

  // Encoding kept numerically identical to the downstream sum_row stage.
  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_FILL   = 3'd1;
  localparam logic [2:0] STATE_READY  = 3'd2;
  localparam logic [2:0] STATE_REFILL = 3'd3;
  localparam logic [2:0] STATE_DONE   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = STATE_IDLE,
    StFill   = STATE_FILL,
    StReady  = STATE_READY,
    StRefill = STATE_REFILL,
    StDone   = STATE_DONE
  } trg_state_e;

endpackage

// File: rtl/toeplitz_row_gen_if.sv
// Row generator bus: start control, seed memory read port, shift handshake and status.
interface toeplitz_row_gen_if;
  import toeplitz_row_gen_pkg::*;

  logic              start;
  logic              seed_rd_en;
  logic [WORD_W-1:0] seed_data;
  logic              shift_en;
  logic [ROW_W-1:0]  shift_row;
  logic              row_valid;
  logic              busy;
  logic              done;
  logic              err;

  // Generator side.
  modport master (
    input  start, seed_data, shift_en,
    output seed_rd_en, shift_row, row_valid, busy, done, err
  );

  // Controller / seed memory / consumer side.
  modport slave (
    output start, seed_data, shift_en,
    input  seed_rd_en, shift_row, row_valid, busy, done, err
  );

endinterface

// File: rtl/toeplitz_seed_fetch.sv
// Seed word fetcher: issues read strobes, captures the word returned one cycle later and
// tells the row register whether the capture is a row-fill word or a stage word.
module toeplitz_seed_fetch
  import toeplitz_row_gen_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fill_start_i,
  input  logic              refill_start_i,
  input  logic [WORD_W-1:0] seed_data_i,
  output logic              seed_rd_en_o,
  output logic              cap_stb_o,
  output logic              cap_fill_o,
  output logic [WORD_W-1:0] cap_word_o
);

  // FILL reads one word per row slot plus the first stage word.
  localparam logic [WORD_CNT_W-1:0] FillReads = WORD_CNT_W'(FILL_WORDS + 1);
  localparam logic [WORD_CNT_W-1:0] RowWords  = WORD_CNT_W'(FILL_WORDS);

  logic                  rd_en_q, rd_en_d;
  logic                  cap_q, cap_d;
  logic                  filling_q, filling_d;
  logic [WORD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [WORD_CNT_W-1:0] cap_cnt_q, cap_cnt_d;

  // Next-state for the strobe train, capture pipeline and word counters.
  always_comb begin
    rd_en_d   = 1'b0;
    cap_d     = rd_en_q;
    filling_d = filling_q;
    rd_cnt_d  = rd_cnt_q;
    cap_cnt_d = cap_cnt_q;
    if (fill_start_i) begin
      rd_en_d   = 1'b1;
      filling_d = 1'b1;
      rd_cnt_d  = '0;
      cap_cnt_d = '0;
    end else begin
      if (rd_en_q && filling_q) begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_d < FillReads) begin
          rd_en_d = 1'b1;
        end else begin
          filling_d = 1'b0;
        end
      end
      if (refill_start_i) begin
        rd_en_d = 1'b1;
      end
      // Saturates after the fill so every later capture selects the stage register.
      if (cap_q && (cap_cnt_q < FillReads)) begin
        cap_cnt_d = cap_cnt_q + 1'b1;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q   <= 1'b0;
      cap_q     <= 1'b0;
      filling_q <= 1'b0;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      cap_q     <= cap_d;
      filling_q <= filling_d;
      rd_cnt_q  <= rd_cnt_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

  assign seed_rd_en_o = rd_en_q;
  assign cap_stb_o    = cap_q;
  assign cap_fill_o   = cap_cnt_q < RowWords;
  assign cap_word_o   = seed_data_i;

endmodule

// File: rtl/toeplitz_row_gen.sv
// Toeplitz row generator: fills a ROW_W-bit row from seed words, then shifts in one stage
// bit per shift_en, refetching a stage word every WORD_W shifts until STEPS shifts are done.
module toeplitz_row_gen
  import toeplitz_row_gen_pkg::*;
(
  input logic                clk_in,
  input logic                rst_n,
  toeplitz_row_gen_if.master bus
);

  trg_state_e            state_q;
  logic [ROW_W-1:0]      shift_row_q;
  logic [WORD_W-1:0]     stage_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [STEP_CNT_W-1:0] step_cnt_q;
  logic                  row_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic                  fill_start;
  logic                  shift_ok;
  logic                  last_step;
  logic                  refill_start;
  logic                  cap_stb;
  logic                  cap_fill;
  logic [WORD_W-1:0]     cap_word;

  // Decode of accepted commands; row_valid_q is high exactly while in StReady.
  always_comb begin
    fill_start   = (state_q == StIdle) && bus.start;
    shift_ok     = (state_q == StReady) && bus.shift_en;
    last_step    = step_cnt_q == STEP_CNT_W'(STEPS - 1);
    refill_start = shift_ok && !last_step && (bit_cnt_q == BIT_CNT_W'(1));
  end

  toeplitz_seed_fetch u_seed_fetch (
    .clk_i          (clk_in),
    .rst_ni         (rst_n),
    .fill_start_i   (fill_start),
    .refill_start_i (refill_start),
    .seed_data_i    (bus.seed_data),
    .seed_rd_en_o   (bus.seed_rd_en),
    .cap_stb_o      (cap_stb),
    .cap_fill_o     (cap_fill),
    .cap_word_o     (cap_word)
  );

  // Control FSM with registered status outputs, row and stage datapath.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_row_q <= '0;
      stage_q     <= '0;
      bit_cnt_q   <= '0;
      step_cnt_q  <= '0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.shift_en && !row_valid_q) begin
        err_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            err_q      <= 1'b0;
            step_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (cap_stb) begin
            if (cap_fill) begin
              // Earlier words migrate towards the MSBs, so word 0 ends on top.
              shift_row_q <= {shift_row_q[ROW_W-WORD_W-1:0], cap_word};
            end else begin
              stage_q     <= cap_word;
              bit_cnt_q   <= BIT_CNT_W'(WORD_W);
              row_valid_q <= 1'b1;
              state_q     <= StReady;
            end
          end
        end
        StReady: begin
          if (shift_ok) begin
            // Stage MSB first, matching coefficient bit 31 being consumed first.
            shift_row_q <= {shift_row_q[ROW_W-2:0], stage_q[WORD_W-1]};
            stage_q     <= {stage_q[WORD_W-2:0], 1'b0};
            bit_cnt_q   <= bit_cnt_q - 1'b1;
            step_cnt_q  <= step_cnt_q + 1'b1;
            if (last_step) begin
              row_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else if (bit_cnt_q == BIT_CNT_W'(1)) begin
              row_valid_q <= 1'b0;
              state_q     <= StRefill;
            end
          end
        end
        StRefill: begin
          if (cap_stb) begin
            stage_q     <= cap_word;
            bit_cnt_q   <= BIT_CNT_W'(WORD_W);
            row_valid_q <= 1'b1;
            state_q     <= StReady;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          row_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.shift_row = shift_row_q;
  assign bus.row_valid = row_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_toeplitz_row_gen.sv
// Randomized scoreboard bench for toeplitz_row_gen. The reference row after n shifts is the
// ROW_W-bit window starting at bit n of the seed bit stream (words in order, MSB first).
module tb_toeplitz_row_gen;
  import toeplitz_row_gen_pkg::*;

  localparam int unsigned NWORDS = FILL_WORDS + STEPS / WORD_W;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  toeplitz_row_gen_if bus ();

  toeplitz_row_gen dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [WORD_W-1:0] mem [NWORDS];
  logic [ROW_W-1:0]  exp_q [$];
  int total = 0;
  int bad = 0;
  int rd_ptr = 0;
  int rd_total = 0;
  int done_cnt = 0;
  int nshift = 0;
  logic prev_v = 1'b0;
  logic prev_acc = 1'b0;

  function automatic logic [ROW_W-1:0] window(input int n);
    logic [ROW_W-1:0] r;
    int j;
    for (int i = 0; i < ROW_W; i++) begin
      j = n + i;
      r[ROW_W-1-i] = mem[j / WORD_W][WORD_W - 1 - (j % WORD_W)];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chk_row(input string nm, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] req);
    int d;
    total++;
    if (act !== req) begin
      bad++;
      d = -1;
      for (int i = ROW_W - 1; i >= 0; i--) if (d < 0 && act[i] !== req[i]) d = i;
      $display("FAIL %s: row differs first at bit %0d, got low word %h required %h",
               nm, d, act[31:0], req[31:0]);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
    chk({nm, "_valid"}, 64'(bus.row_valid), 64'd0);
    chk({nm, "_rd"}, 64'(bus.seed_rd_en), 64'd0);
    chk({nm, "_done"}, 64'(bus.done), 64'd0);
    chk({nm, "_err"}, 64'(bus.err), 64'd0);
    chk_row({nm, "_row"}, bus.shift_row, '0);
  endtask

  // Seed memory: the word appears the cycle after its strobe.
  initial begin
    logic rd;
    forever begin
      @(negedge clk_in);
      rd = bus.seed_rd_en;
      @(posedge clk_in);
      if (rd) begin
        bus.seed_data <= (rd_ptr < NWORDS) ? mem[rd_ptr] : '0;
        rd_ptr++;
        rd_total++;
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (bus.done) done_cnt++;
  end

  // Monitor: a new row is visible after each accepted shift, on each row_valid rise and on done.
  initial begin
    logic [ROW_W-1:0] e;
    forever begin
      @(negedge clk_in);
      if (bus.done || (bus.row_valid && (!prev_v || prev_acc))) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: row presented with no expected row queued");
        end else begin
          e = exp_q.pop_front();
          chk_row("sb_row", bus.shift_row, e);
        end
      end
      prev_v   = bus.row_valid;
      prev_acc = bus.row_valid && bus.shift_en;
    end
  end

  // Start a block and measure the fill: cycles until row_valid, strobe count and span.
  task automatic do_fill(input int ghost_at, output int cyc, output int rds, output int span);
    int n, first, last;
    exp_q.push_back(window(0));
    @(posedge clk_in); #1 bus.start = 1'b1;
    @(posedge clk_in); #1 bus.start = 1'b0;
    n = 0; rds = 0; first = -1; last = -1;
    while (n < 300) begin
      @(negedge clk_in);
      bus.start = (n == ghost_at);
      if (bus.row_valid) break;
      if (bus.seed_rd_en) begin
        rds++;
        if (first < 0) first = n;
        last = n;
      end
      n++;
    end
    bus.start = 1'b0;
    cyc  = n;
    span = last - first;
  endtask

  // Random-gap shifts honouring row_valid until nshift reaches target.
  task automatic shift_random(input int target);
    int guard = 0;
    while (nshift < target && guard < 40000) begin
      @(posedge clk_in); #1;
      if (bus.row_valid && $urandom_range(0, 1) == 1) begin
        bus.shift_en = 1'b1;
        nshift++;
        exp_q.push_back(window(nshift));
      end else begin
        bus.shift_en = 1'b0;
      end
      guard++;
    end
    if (guard >= 40000) begin
      total++;
      bad++;
      $display("FAIL shift_timeout: reached %0d shifts required %0d", nshift, target);
    end
    @(posedge clk_in); #1 bus.shift_en = 1'b0;
  endtask

  initial begin
    int cyc, rds, span, viol;
    logic [ROW_W-1:0] row_a, snap;
    bus.start = 1'b0;
    bus.shift_en = 1'b0;
    bus.seed_data = '0;

    // Reset asserted mid-clock, then a quiet idle period.
    #3 rst_n = 1'b0;
    #1 chk_zero("rst_init");
    repeat (2) @(posedge clk_in);
    #2 rst_n = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (bus.busy || bus.seed_rd_en) viol++;
    end
    chk("idle_quiet", 64'(viol), 64'd0);

    // Block 1: word k = k, full randomized block.
    for (int k = 0; k < NWORDS; k++) mem[k] = WORD_W'(k);
    rd_ptr = 0; rd_total = 0; nshift = 0; done_cnt = 0;
    do_fill(-1, cyc, rds, span);
    chk("fill_cycles", 64'(cyc), 64'd98);
    chk("fill_reads", 64'(rds), 64'(FILL_WORDS + 1));
    chk("fill_span", 64'(span), 64'(FILL_WORDS));
    chk("fill_row_msw", 64'(bus.shift_row[ROW_W-1 -: 32]), 64'd0);
    chk("fill_row_lsw", 64'(bus.shift_row[31:0]), 64'd95);
    chk("fill_busy", 64'(bus.busy), 64'd1);
    row_a = bus.shift_row;
    shift_random(STEPS);
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("busy_at_done", 64'(bus.busy), 64'd1);
    @(posedge clk_in); #1;
    chk("done_cleared", 64'(bus.done), 64'd0);
    chk("busy_fall", 64'(bus.busy), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("reads_total", 64'(rd_total), 64'(NWORDS));
    chk_row("final_row", bus.shift_row, window(STEPS));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // Illegal shift in IDLE: err set, row held.
    snap = bus.shift_row;
    @(posedge clk_in); #1 bus.shift_en = 1'b1;
    @(posedge clk_in); #1 bus.shift_en = 1'b0;
    chk("idle_shift_err", 64'(bus.err), 64'd1);
    chk_row("idle_row_hold", bus.shift_row, snap);

    // Block 2: random seeds with stage word 0x80000001; bit order and refill stall.
    for (int k = 0; k < NWORDS; k++) mem[k] = $urandom();
    mem[FILL_WORDS] = 32'h8000_0001;
    rd_ptr = 0; nshift = 0;
    do_fill(-1, cyc, rds, span);
    chk("b2_fill_cycles", 64'(cyc), 64'd98);
    chk("start_clears_err", 64'(bus.err), 64'd0);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk_in); #1;
      if (k > 1) chk($sformatf("lsb_shift%0d", k - 1), 64'(bus.shift_row[0]),
                     64'(mem[FILL_WORDS][WORD_W - (k - 1)]));
      bus.shift_en = 1'b1;
      nshift = k;
      exp_q.push_back(window(k));
    end
    @(posedge clk_in); #1;
    chk("lsb_shift32", 64'(bus.shift_row[0]), 64'(mem[FILL_WORDS][0]));
    chk("stall1_valid", 64'(bus.row_valid), 64'd0);
    chk("stall1_rd", 64'(bus.seed_rd_en), 64'd1);
    snap = bus.shift_row;
    bus.shift_en = 1'b1;
    @(posedge clk_in); #1 bus.shift_en = 1'b0;
    chk("stall2_valid", 64'(bus.row_valid), 64'd0);
    chk("stall2_rd", 64'(bus.seed_rd_en), 64'd0);
    chk("stall_err", 64'(bus.err), 64'd1);
    chk_row("stall_row_hold", bus.shift_row, snap);
    @(posedge clk_in); #1;
    chk("resume_valid", 64'(bus.row_valid), 64'd1);
    chk_row("resume_row", bus.shift_row, snap);

    // Abort inside the next refill.
    shift_random(64);
    chk("abort_in_refill", 64'(bus.row_valid), 64'd0);
    chk("abort_refill_rd", 64'(bus.seed_rd_en), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    exp_q.delete();
    repeat (3) @(posedge clk_in);
    #2 rst_n = 1'b1;

    // Block 3: rerun the block-1 fill with a stray start during FILL and READY.
    for (int k = 0; k < NWORDS; k++) mem[k] = WORD_W'(k);
    rd_ptr = 0; nshift = 0;
    do_fill(40, cyc, rds, span);
    chk("rerun_cycles", 64'(cyc), 64'd98);
    chk("rerun_reads", 64'(rds), 64'(FILL_WORDS + 1));
    chk_row("rerun_row", bus.shift_row, row_a);
    @(posedge clk_in); #1 bus.start = 1'b1;
    @(posedge clk_in); #1 bus.start = 1'b0;
    chk("ready_start_valid", 64'(bus.row_valid), 64'd1);
    chk("ready_start_rd", 64'(bus.seed_rd_en), 64'd0);
    chk_row("ready_start_row", bus.shift_row, row_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toeplitz_row_gen.md
Name: toeplitz_row_gen

Overview:
Upstream feeder for the Toeplitz row-accumulate stage (sum_row).
- Builds the 3072-bit Toeplitz row from a 32-bit seed-word stream.
- Presents the row on shift_row and advances it by one seed bit per shift_en pulse, i.e. once per coefficient bit consumed downstream.
- Stalls briefly, with row_valid low, while it fetches the next seed word.

Parameters:
ROW_W, 3072, width of the Toeplitz row / shift_row.
WORD_W, 32, seed word width.
FILL_WORDS, ROW_W/WORD_W (96), words needed for the initial row.
STEPS, 4096, single-bit shifts per hash block (= 128 words x 32 coefficient bits).

Ports:
clk_in  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins a new block (accepted in IDLE only).
seed_rd_en  out  1  seed memory read strobe; data is returned exactly 1 cycle later.
seed_data  in  WORD_W  seed word, valid the cycle after seed_rd_en.
shift_en  in  1  advance the row by one bit; legal only while row_valid=1.
shift_row  out  ROW_W  current Toeplitz row.
row_valid  out  1  shift_row is stable and may be sampled or shifted.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the STEPS-th shift.
err  out  1  sticky flag: shift_en was seen while row_valid=0; cleared by start or reset.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs are 0, shift_row=0, stage word=0, all counters=0, state=IDLE.
- States: IDLE, FILL, READY, REFILL, DONE.
- IDLE: on start, clear err, step_cnt, rd_cnt and cap_cnt, then go to FILL. start in any other state is ignored.
- FILL:
  - Assert seed_rd_en on FILL_WORDS+1 (97) consecutive cycles.
  - Each returned word is captured 1 cycle after its strobe.
  - Captures 0..95 load the row as shift_row <= {shift_row[ROW_W-33:0], seed_data}, so word 0 ends up in the MSBs.
  - Capture 96 loads the 32-bit stage register and sets bit_cnt=32.
  - Go to READY on the cycle after capture 96.
  - FILL lasts 98 cycles from entry to READY.
- READY: row_valid=1. On shift_en:
  - shift_row <= {shift_row[ROW_W-2:0], stage[31]}
  - stage <= stage<<1
  - bit_cnt-1 and step_cnt+1.
  - If that shift makes step_cnt=STEPS, go to DONE.
  - Otherwise, if bit_cnt reaches 0, go to REFILL.
  - The MSB-first bit order matches the coefficient bit order downstream (coefficient bit 31 first).
- REFILL: row_valid=0.
  - Cycle 1: seed_rd_en=1.
  - Cycle 2: capture seed_data into stage, bit_cnt=32.
  - Cycle 3: back in READY.
  - shift_row is held unchanged throughout.
- DONE: done=1 for one cycle, row_valid=0, then IDLE. shift_row is held until the next start.
- row_valid is registered and goes low in the same edge that leaves READY.
- Total seed reads per block: 96 + 128 = 224.
- shift_en while row_valid=0: ignored (no row change) and err is set.
- shift_en in the same cycle as a state exit: the exit is caused by that same shift and behaves as specified above.
- Reset mid-operation: immediate return to the reset values above; no partial row is retained.
- Counter widths: step_cnt 13 bits (holds 4096); rd_cnt and cap_cnt 7 bits; bit_cnt 6 bits.

Decomposition:
- Shared package holds:
  - the ROW_W, WORD_W and STEPS constants;
  - the state encoding localparams (IDLE=0, FILL=1, READY=2, REFILL=3, DONE=4), 3 bits, shared style with sum_row.
- Natural sub-module: toeplitz_seed_fetch. It owns seed_rd_en, the 1-cycle return capture and the word counters. It hands words to the row register with a capture strobe plus a fill/stage select.

Test Plan:
1. Reset and idle: assert rst_n=0 mid-clock -> all outputs 0 immediately; release with no start -> busy=0 and seed_rd_en=0 for 20 cycles.
2. Initial fill: memory returns word k = k (0..96); pulse start:
   - exactly 97 seed_rd_en cycles, back-to-back;
   - row_valid rises at cycle 98;
   - shift_row[3071:3040]=0 and shift_row[31:0]=95;
   - stage=96.
3. Single-bit shifts: stage word 0x80000001; apply shift_en -> new shift_row[0]=1, remaining bits are the old row<<1; apply 30 more shifts -> each new LSB=0; the 32nd shift -> LSB=1.
4. Refill stall: after the 32nd shift, row_valid=0 for exactly 2 cycles with one seed_rd_en; shift_row stays stable; then row_valid=1. Drive shift_en during the stall -> err=1 and shift_row unchanged.
5. Full block: issue 4096 shift_en with random gaps, honouring row_valid:
   - done pulses once, 1 cycle after the last shift;
   - 224 total seed reads;
   - busy falls 1 cycle after done;
   - the final row matches the reference model shift of seed words 0..223.
6. Abort and restart: drop rst_n during REFILL -> everything clears; a new start reruns scenario 2 with an identical result. A start pulse while busy -> ignored, with no counter change.
